// File: rtl/mult_seq_32bit_if.sv
// rtl/mult_seq_32bit_if.sv - request/result and add/sub operand bus for the sequential multiplier
//
// Purpose: bundles the multiply request/result handshake and the operand/result
// lanes shared with the 32-bit add/sub stage.
// Ports (signals):
//   start, a[31:0], b[31:0]      request pulse and operands (into the multiplier)
//   busy, done, product[63:0]    status and result (out of the multiplier)
//   add_a, add_b[31:0], add_op   operands and opcode driven to the add/sub stage
//   add_res[31:0]                combinational sum returned by the add/sub stage
// Modports: slave = multiplier side, master = requester / environment side.

interface mult_seq_32bit_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_op;
  logic [31:0] add_res;

  modport slave (
    input  start, a, b, add_res,
    output busy, done, product, add_a, add_b, add_op
  );

  modport master (
    output start, a, b, add_res,
    input  busy, done, product, add_a, add_b, add_op
  );
endinterface

// File: rtl/mult_seq_32bit.sv
// rtl/mult_seq_32bit.sv - sequential unsigned 32x32->64 shift-add multiplier
//
// Purpose: one shift-add iteration per clock using the shared add/sub stage,
// fixed 32-cycle latency from accepted start to done.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (priority over start)
//   bus    mult_seq_32bit_if.slave: start/a/b in, busy/done/product out,
//          add_a/add_b/add_op out to add/sub stage, add_res back from it

module mult_seq_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  mult_seq_32bit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [WIDTH-1:0]       m;
  logic [2*WIDTH-1:0]     p;
  logic [CNT_W-1:0]       cnt;
  logic                   load;
  logic                   last;
  logic                   carry;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // The add/sub stage has no carry-out; recover it from the operand and sum
  // MSBs: carry if both MSBs set, or one set and the sum MSB came out clear.
  assign carry = (p[2*WIDTH-1] & m[WIDTH-1]) |
                 ((p[2*WIDTH-1] | m[WIDTH-1]) & ~bus.add_res[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m   <= '0;
      p   <= '0;
      cnt <= '0;
    end else if (load) begin
      m   <= bus.a;
      p   <= {{WIDTH{1'b0}}, bus.b};
      cnt <= '0;
    end else if (state == CALC) begin
      // Low half holds the unconsumed multiplier bits; its LSB selects add-or-skip.
      if (p[0]) begin
        p <= {carry, bus.add_res, p[WIDTH-1:1]};
      end else begin
        p <= {1'b0, p[2*WIDTH-1:1]};
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = (state == DONE);
  assign bus.product = p;
  assign bus.add_a   = p[2*WIDTH-1:WIDTH];
  assign bus.add_b   = m;
  assign bus.add_op  = 1'b0;

endmodule
